byte_data_mem: RTL and testbench

BYTE_DATA_MEM -- requirements
Module: byte_data_mem

---
 rtl/byte_data_mem.sv | 133 +++++++++++++
 tb/tb_byte_data_mem.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_mem.sv
// Byte-addressable RISC-V data memory: clears itself after reset, then serves LB/LH/LW/LBU/LHU/SB/SH/SW with a 1-cycle response.
// Optional macro DATAMEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of ignoring the low address bits.
module byte_data_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic INIT = 1'b0;
  localparam logic RUN  = 1'b1;

  logic          state;
  logic [AW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic [1:0]    hoff;
  logic          accept;
  logic          oor;
  logic          bad_code;
  logic          misal;
  logic          err;
  logic          we_fire;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rword;
  logic [31:0]   bsh;
  logic [31:0]   hsh;
  logic [31:0]   ld;

  assign widx      = req_addr[AW+1:2];
  assign off       = req_addr[1:0];
  assign hoff      = {req_addr[1], 1'b0};
  assign accept    = req_valid && req_ready;
  assign oor       = (req_addr >> (AW + 2)) != '0;
  assign req_ready = (state == RUN);
  assign busy      = (state == INIT);
  assign rword     = mem[widx];
  assign bsh       = rword >> {off, 3'b000};
  assign hsh       = rword >> {hoff, 3'b000};

  // funct3[1:0] encodes access size; only the size matters for alignment
`ifdef DATAMEM_MISALIGN_TRAP_EN
  assign misal = (req_funct3[1:0] == 2'b01) ? off[0] :
                 (req_funct3[1:0] == 2'b10) ? (off != 2'b00) : 1'b0;
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    bad_code = 1'b0;
    be       = 4'b0000;
    wd       = '0;
    ld       = '0;
    if (req_we) begin
      case (req_funct3)
        3'b000: begin
          be = 4'b0001 << off;
          wd = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          be = 4'b0011 << hoff;
          wd = {2{req_wdata[15:0]}};
        end
        3'b010: begin
          be = 4'b1111;
          wd = req_wdata;
        end
        default: bad_code = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  ld = {{24{bsh[7]}}, bsh[7:0]};
        3'b100:  ld = {24'd0, bsh[7:0]};
        3'b001:  ld = {{16{hsh[15]}}, hsh[15:0]};
        3'b101:  ld = {16'd0, hsh[15:0]};
        3'b010:  ld = rword;
        default: bad_code = 1'b1;
      endcase
    end
  end

  assign err     = bad_code || oor || misal;
  assign we_fire = accept && req_we && !err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) state <= RUN;
    end
  end

  // Array has no reset: the INIT sweep is what defines its contents
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (we_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && err;
      rsp_rdata <= (accept && !req_we && !err) ? ld : '0;
    end
  end

endmodule

// File: tb/tb_byte_data_mem.sv
// Randomized self-checking bench for byte_data_mem against a byte-array reference model.
module tb_byte_data_mem;

  localparam int DEPTH = 256;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  bm [NBYTE];
  logic [31:0] got_rdata;
  logic        got_err;

  byte_data_mem #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses described by size/sign/address
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a_in,
                       input logic [31:0] wdat, output logic err, output logic [31:0] rd);
    int          size;
    bit          sext;
    logic [31:0] a;
    err  = 1'b0;
    rd   = '0;
    size = 0;
    sext = 1'b0;
    a    = a_in;
    if (we) begin
      case (f3)
        3'b000:  size = 1;
        3'b001:  size = 2;
        3'b010:  size = 4;
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000:  begin size = 1; sext = 1'b1; end
        3'b100:  size = 1;
        3'b001:  begin size = 2; sext = 1'b1; end
        3'b101:  size = 2;
        3'b010:  size = 4;
        default: err = 1'b1;
      endcase
    end
    if (a >= NBYTE) err = 1'b1;
    if (!err) begin
`ifdef DATAMEM_MISALIGN_TRAP_EN
      if (a % size != 0) err = 1'b1;
`else
      a = a - (a % size);
`endif
    end
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) bm[a + i] = wdat[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = bm[a + i];
        if (sext && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFFFFFF << (8*size));
      end
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wdat);
    logic        e;
    logic [31:0] r;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wdat;
    model(we, f3, a, wdat, e, r);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdata", rsp_rdata, r);
    chk("rsp_err", 32'(rsp_err), 32'(e));
    got_rdata  = rsp_rdata;
    got_err    = rsp_err;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic idle();
    @(negedge clk);
    chk("idle_vld", 32'(rsp_valid), 0);
  endtask

  task automatic sweep_check();
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (busy && n < 2000) begin
      if (req_ready) rdy_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("init_len", 32'(n), 32'(DEPTH));
    chk("init_rdy", 32'(rdy_seen), 0);
    chk("post_ready", 32'(req_ready), 1);
    for (int i = 0; i < NBYTE; i++) bm[i] = 8'h00;
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    rst = 1'b0;
    sweep_check();

    send(0, 3'b010, 32'h0, 0);     chk("lw0_init", got_rdata, 0);
    send(0, 3'b010, 32'h3FC, 0);   chk("lw3fc_init", got_rdata, 0);
    chk("lw3fc_err", 32'(got_err), 0);

    send(1, 3'b010, 32'h10, 32'h11223344);
    send(1, 3'b000, 32'h11, 32'h000000AB);
    send(1, 3'b001, 32'h12, 32'h0000BEEF);
    send(0, 3'b010, 32'h10, 0);    chk("lw10", got_rdata, 32'hBEEFAB44);
    send(0, 3'b000, 32'h11, 0);    chk("lb11", got_rdata, 32'hFFFFFFAB);
    send(0, 3'b100, 32'h11, 0);    chk("lbu11", got_rdata, 32'h000000AB);
    send(0, 3'b001, 32'h12, 0);    chk("lh12", got_rdata, 32'hFFFFBEEF);
    send(0, 3'b101, 32'h12, 0);    chk("lhu12", got_rdata, 32'h0000BEEF);
    idle();

    send(1, 3'b010, 32'h20, 32'hCAFEF00D);
    send(0, 3'b010, 32'h20, 0);    chk("b2b_lw", got_rdata, 32'hCAFEF00D);
    idle();

    send(0, 3'b010, 32'h400, 0);   chk("oor_err", 32'(got_err), 1);
    chk("oor_rdata", got_rdata, 0);
    send(0, 3'b111, 32'h0, 0);     chk("f3_111_err", 32'(got_err), 1);
    send(1, 3'b010, 32'h400, 32'hDEADBEEF);
    send(0, 3'b010, 32'h0, 0);     chk("oor_nowrite", got_rdata, 0);

    send(0, 3'b001, 32'h13, 0);
`ifdef DATAMEM_MISALIGN_TRAP_EN
    chk("lh13_err", 32'(got_err), 1);
    chk("lh13_rdata", got_rdata, 0);
`else
    chk("lh13_rdata", got_rdata, 32'hFFFFBEEF);
    chk("lh13_err", 32'(got_err), 0);
`endif
    idle();

    send(1, 3'b010, 32'h40, 32'h12345678);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_vld", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("midrst_vld2", 32'(rsp_valid), 0);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 1);
    sweep_check();
    send(0, 3'b010, 32'h40, 0);    chk("midrst_cleared", got_rdata, 0);

    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r < 7)      a = $urandom_range(0, 63);
      else if (r < 9) a = $urandom_range(0, 1100);
      else            a = $urandom;
      send(we, f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
